load_store_unit: RTL and testbench

Memory-access stage of the RISC-V core, directly downstream of the ALU. It takes the ALU result as the effective address, together with the load/store type and store data. It performs one data-bus transaction through a request/acknowledge handshake, aligns and extends load data, and reports alignment, illegal-size and bus-timeout faults. While a transaction is in flight it stalls the core.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/acknowledge bus transaction per core access,
// with store lane replication, load extraction/extension and fault reporting.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_reg;
    logic [7:0]  cnt_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;

    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign lsu_stall = lsu_valid & ~lsu_done;

    // Request classification straight from the core inputs, checked while IDLE.
    assign is_half    = (lsu_funct3[1:0] == 2'b01);
    assign is_word    = lsu_funct3[1];
    assign illegal    = lsu_store ? lsu_funct3[2]
                                  : ((lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11));
    assign misaligned = (is_half & lsu_addr[0]) | (is_word & (lsu_addr[1:0] != 2'b00));

    always_comb begin
        lane_wdata = lsu_wdata;
        lane_wstrb = 4'b1111;
        case (lsu_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{lsu_wdata[7:0]}};
                lane_wstrb = 4'b0001 << lsu_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{lsu_wdata[15:0]}};
                lane_wstrb = 4'b0011 << lsu_addr[1:0];
            end
            default: begin
                lane_wdata = lsu_wdata;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_byte[off_reg];
    assign half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 8'd0;
            funct3_reg   <= 3'd0;
            off_reg      <= 2'd0;
            lsu_done     <= 1'b0;
            lsu_rdata    <= 32'd0;
            lsu_err      <= 1'b0;
            lsu_err_code <= CODE_NONE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'b0000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (lsu_valid) begin
                        if (illegal || misaligned) begin
                            // Faulty requests never reach the bus.
                            state_reg    <= ST_DONE;
                            lsu_done     <= 1'b1;
                            lsu_err      <= 1'b1;
                            lsu_err_code <= illegal ? CODE_ILLEGAL : CODE_MISALIGN;
                        end else begin
                            state_reg  <= ST_REQ;
                            cnt_reg    <= 8'd0;
                            funct3_reg <= lsu_funct3;
                            off_reg    <= lsu_addr[1:0];
                            mem_req    <= 1'b1;
                            mem_we     <= lsu_store;
                            mem_addr   <= {lsu_addr[31:2], 2'b00};
                            mem_wdata  <= lsu_store ? lane_wdata : 32'd0;
                            mem_wstrb  <= lsu_store ? lane_wstrb : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked before expiry so a last-cycle ack still succeeds.
                    if (mem_ack) begin
                        state_reg    <= ST_DONE;
                        mem_req      <= 1'b0;
                        lsu_done     <= 1'b1;
                        lsu_err      <= 1'b0;
                        lsu_err_code <= CODE_NONE;
                        if (!mem_we) begin
                            lsu_rdata <= load_ext;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg    <= ST_DONE;
                        mem_req      <= 1'b0;
                        lsu_done     <= 1'b1;
                        lsu_err      <= 1'b1;
                        lsu_err_code <= CODE_TIMEOUT;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    lsu_done     <= 1'b0;
                    lsu_err      <= 1'b0;
                    lsu_err_code <= CODE_NONE;
                    mem_we       <= 1'b0;
                    mem_wstrb    <= 4'b0000;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: a bus responder with a word memory model,
// and a scoreboard queue of expected completions compared as each access finishes.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_store = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [1:0]  lsu_err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_store(lsu_store), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err), .lsu_err_code(lsu_err_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          cyc;
    } res_t;

    res_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_model [256];
    logic [31:0] last_rdata = 32'd0;

    // Observations of the most recent transaction.
    int          o_cyc;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [1:0]  o_code;
    int          o_req_cycles;
    logic        o_unstable;
    logic        o_stall_bad;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request (cycle 0 = now) and plays the bus: ack after ack_wait
    // unacknowledged request cycles (negative = never). Ends one cycle after lsu_done.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int ack_wait);
        int   cyc = 0;
        logic got = 1'b0;
        logic [7:0] idx;
        lsu_valid = 1'b1; lsu_store = st; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
        o_cyc = -1; o_req_cycles = 0; o_unstable = 1'b0; o_stall_bad = 1'b0;
        o_rdata = 32'hx; o_err = 1'bx; o_code = 2'bx;
        o_addr = 32'hx; o_wdata = 32'hx; o_wstrb = 4'hx; o_we = 1'bx;
        while (!got && cyc < 40) begin
            step();
            cyc++;
            mem_ack = 1'b0;
            mem_rdata = 32'hDEADBEEF;
            if (lsu_stall !== ~lsu_done) o_stall_bad = 1'b1;
            if (mem_req === 1'b1) begin
                if (o_req_cycles == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_wstrb !== o_wstrb || mem_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                if (o_req_cycles == ack_wait) begin
                    mem_ack = 1'b1;
                    idx = mem_addr[9:2];
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) mem_model[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = mem_model[idx];
                    end
                end
                o_req_cycles++;
            end
            if (lsu_done === 1'b1) begin
                got = 1'b1;
                o_cyc = cyc; o_rdata = lsu_rdata; o_err = lsu_err; o_code = lsu_err_code;
            end
        end
        lsu_valid = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_cmp++;
        if ({mem_req, mem_we, lsu_done, lsu_err, lsu_err_code, mem_wstrb} !== 10'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || lsu_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: req=%b we=%b done=%b err=%b code=%b strb=%b addr=%h wdata=%h rdata=%h, all required 0",
                     mem_req, mem_we, lsu_done, lsu_err, lsu_err_code, mem_wstrb, mem_addr, mem_wdata, lsu_rdata);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (lsu_stall !== 1'b0 || lsu_done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: stall=%b done=%b, required 0 0", lsu_stall, lsu_done);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233, 32'h80112233};
        res_t e;
        mem_model[8'h40] = 32'h80112233;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{exs[i], 1'b0, 2'b00, 2});
            run_txn(1'b0, f3s[i], ads[i], 32'd0, 0);
            e = exp_q.pop_front();
            last_rdata = e.rdata;
            n_cmp++;
            if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc) begin
                n_bad++;
                $display("FAIL load_%0d: rdata=%h err=%b code=%b done_cyc=%0d, want %h %b %b %0d",
                         i, o_rdata, o_err, o_code, o_cyc, e.rdata, e.err, e.code, e.cyc);
            end
            n_cmp++;
            if (o_addr !== 32'h100 || o_we !== 1'b0 || o_wstrb !== 4'b0000 || o_stall_bad !== 1'b0) begin
                n_bad++;
                $display("FAIL load_bus_%0d: addr=%h we=%b strb=%b stall_bad=%b, want 00000100 0 0000 0",
                         i, o_addr, o_we, o_wstrb, o_stall_bad);
            end
            $display("load f3=%b addr=%h -> rdata=%h cyc=%0d", f3s[i], ads[i], o_rdata, o_cyc);
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s [2] = '{3'b001, 3'b000};
        logic [31:0] ads [2] = '{32'h202, 32'h201};
        logic [31:0] wds [2] = '{32'hAAAA1234, 32'h0000775A};
        int          aws [2] = '{3, 0};
        logic [31:0] ewd [2] = '{32'h12341234, 32'h5A5A5A5A};
        logic [3:0]  est [2] = '{4'b1100, 4'b0010};
        int          erq [2] = '{4, 1};
        res_t e;
        mem_model[8'h80] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{last_rdata, 1'b0, 2'b00, aws[i] + 2});
            run_txn(1'b1, f3s[i], ads[i], wds[i], aws[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc) begin
                n_bad++;
                $display("FAIL store_%0d: rdata=%h err=%b code=%b done_cyc=%0d, want %h %b %b %0d",
                         i, o_rdata, o_err, o_code, o_cyc, e.rdata, e.err, e.code, e.cyc);
            end
            n_cmp++;
            if (o_addr !== 32'h200 || o_we !== 1'b1 || o_wstrb !== est[i] || o_wdata !== ewd[i] ||
                o_req_cycles != erq[i] || o_unstable !== 1'b0 || o_stall_bad !== 1'b0) begin
                n_bad++;
                $display("FAIL store_bus_%0d: addr=%h we=%b strb=%b wdata=%h req_cyc=%0d unstable=%b stall_bad=%b, want 00000200 1 %b %h %0d 0 0",
                         i, o_addr, o_we, o_wstrb, o_wdata, o_req_cycles, o_unstable, o_stall_bad, est[i], ewd[i], erq[i]);
            end
            $display("store f3=%b addr=%h -> strb=%b wdata=%h cyc=%0d", f3s[i], ads[i], o_wstrb, o_wdata, o_cyc);
        end
        n_cmp++;
        if (mem_model[8'h80] !== 32'h12345A00) begin
            n_bad++;
            $display("FAIL store_memory: word=%h, want 12345a00", mem_model[8'h80]);
        end
    endtask

    task automatic test_faults();
        logic        sts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b011, 3'b001};
        logic [31:0] ads [6] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h101, 32'h203};
        logic [1:0]  ecs [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01};
        res_t e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{last_rdata, 1'b1, ecs[i], 1});
            run_txn(sts[i], f3s[i], ads[i], 32'h11223344, 0);
            e = exp_q.pop_front();
            n_cmp++;
            if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc ||
                o_req_cycles != 0) begin
                n_bad++;
                $display("FAIL fault_%0d: rdata=%h err=%b code=%b done_cyc=%0d req_cyc=%0d, want %h %b %b %0d 0",
                         i, o_rdata, o_err, o_code, o_cyc, o_req_cycles, e.rdata, e.err, e.code, e.cyc);
            end
            $display("fault st=%b f3=%b addr=%h -> err=%b code=%b", sts[i], f3s[i], ads[i], o_err, o_code);
        end
    endtask

    task automatic test_timeout();
        int          aws [2] = '{-1, T - 1};
        logic        ees [2] = '{1'b1, 1'b0};
        logic [1:0]  ecs [2] = '{2'b10, 2'b00};
        res_t e;
        mem_model[8'h41] = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{(i == 0) ? last_rdata : 32'hCAFEF00D, ees[i], ecs[i], T + 1});
            run_txn(1'b0, 3'b010, 32'h104, 32'd0, aws[i]);
            e = exp_q.pop_front();
            last_rdata = e.rdata;
            n_cmp++;
            if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc ||
                o_req_cycles != T) begin
                n_bad++;
                $display("FAIL timeout_%0d: rdata=%h err=%b code=%b done_cyc=%0d req_cyc=%0d, want %h %b %b %0d %0d",
                         i, o_rdata, o_err, o_code, o_cyc, o_req_cycles, e.rdata, e.err, e.code, e.cyc, T);
            end
            $display("timeout case %0d -> err=%b code=%b cyc=%0d", i, o_err, o_code, o_cyc);
        end
    endtask

    task automatic test_reset_mid();
        res_t e;
        int   saw_done = 0;
        lsu_valid = 1'b1; lsu_store = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h104;
        step(); step();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_req: mem_req=%b, want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_rdata !== 32'd0 || mem_addr !== 32'd0 ||
            lsu_err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_drop: req=%b done=%b rdata=%h addr=%h code=%b, want 0 0 0 0 0",
                     mem_req, lsu_done, lsu_rdata, mem_addr, lsu_err_code);
        end
        lsu_valid = 1'b0;
        last_rdata = 32'd0;
        step();
        if (lsu_done !== 1'b0) saw_done++;
        rst_n = 1'b1;
        step();
        if (lsu_done !== 1'b0) saw_done++;
        n_cmp++;
        if (saw_done != 0) begin
            n_bad++;
            $display("FAIL reset_mid_nodone: done seen %0d times, want 0", saw_done);
        end
        exp_q.push_back('{32'hCAFEF00D, 1'b0, 2'b00, 3});
        run_txn(1'b0, 3'b010, 32'h104, 32'd0, 1);
        e = exp_q.pop_front();
        last_rdata = e.rdata;
        n_cmp++;
        if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc) begin
            n_bad++;
            $display("FAIL reset_mid_after: rdata=%h err=%b code=%b done_cyc=%0d, want %h %b %b %0d",
                     o_rdata, o_err, o_code, o_cyc, e.rdata, e.err, e.code, e.cyc);
        end
        $display("reset mid-REQ -> req dropped, next LW rdata=%h cyc=%0d", o_rdata, o_cyc);
    endtask

    task automatic test_back_to_back();
        logic        sts [2] = '{1'b1, 1'b0};
        int          aws [2] = '{0, 2};
        res_t e;
        mem_model[8'hC0] = 32'h0;
        exp_q.push_back('{last_rdata, 1'b0, 2'b00, 2});
        exp_q.push_back('{32'h13579BDF, 1'b0, 2'b00, 4});
        for (int i = 0; i < 2; i++) begin
            run_txn(sts[i], 3'b010, 32'h300, 32'h13579BDF, aws[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (o_rdata !== e.rdata || o_err !== e.err || o_code !== e.code || o_cyc != e.cyc ||
                o_stall_bad !== 1'b0 || o_addr !== 32'h300) begin
                n_bad++;
                $display("FAIL b2b_%0d: rdata=%h err=%b code=%b done_cyc=%0d stall_bad=%b addr=%h, want %h %b %b %0d 0 00000300",
                         i, o_rdata, o_err, o_code, o_cyc, o_stall_bad, o_addr, e.rdata, e.err, e.code, e.cyc);
            end
            $display("b2b %s 0x300 -> rdata=%h cyc=%0d", sts[i] ? "SW" : "LW", o_rdata, o_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
